// File: rtl/wvb_rd_sequencer.sv
// Readout sequencer for one waveform buffer channel: pops an event header, walks
// the sample range start..stop (with wrap) under backpressure, and aligns framing to RAM output.
module wvb_rd_sequencer #(
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_RD_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   hdr_empty,
  input  logic [P_HDR_WIDTH-1:0] hdr_data,
  input  logic [P_ADR_WIDTH-1:0] hdr_start_addr,
  input  logic [P_ADR_WIDTH-1:0] hdr_stop_addr,
  input  logic                   dout_rdy,
  output logic                   hdr_rdreq,
  output logic                   wvb_rdreq,
  output logic                   wvb_rddone,
  output logic [P_HDR_WIDTH-1:0] evt_hdr,
  output logic                   hdr_valid,
  output logic                   dout_valid,
  output logic                   dout_last,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_WAIT = 3'd2,
    S_SAMP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [P_ADR_WIDTH:0] REM_ZERO = {(P_ADR_WIDTH+1){1'b0}};
  localparam logic [P_ADR_WIDTH:0] REM_ONE  = {{P_ADR_WIDTH{1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic                    wait_q, wait_d;
  logic [P_ADR_WIDTH:0]    remaining_q, remaining_d;
  logic [P_HDR_WIDTH-1:0]  evt_hdr_q, evt_hdr_d;
  logic [P_RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [P_RD_LATENCY-1:0] last_pipe_q, last_pipe_d;
  logic                    hdr_rdreq_q, hdr_rdreq_d;
  logic                    hdr_valid_q, hdr_valid_d;
  logic                    rddone_q, rddone_d;
  logic                    busy_q, busy_d;
  logic                    rd_fire;
  logic                    start_ok;
  logic [P_ADR_WIDTH-1:0]  span;

  // Next-state, sample counting and framing pipe.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    remaining_d = remaining_q;
    evt_hdr_d   = evt_hdr_q;
    hdr_valid_d = 1'b0;
    rd_fire     = 1'b0;
    start_ok    = en && !hdr_empty;
    span        = hdr_stop_addr - hdr_start_addr;

    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_HDR;
        else          state_d = S_IDLE;
      end
      S_HDR: begin
        state_d = S_WAIT;
        wait_d  = 1'b0;
      end
      S_WAIT: begin
        // Header FIFO output is only stable in the second WAIT cycle.
        if (wait_q) begin
          evt_hdr_d   = hdr_data;
          remaining_d = {1'b0, span} + REM_ONE;
          hdr_valid_d = 1'b1;
          state_d     = S_SAMP;
        end else begin
          wait_d = 1'b1;
        end
      end
      S_SAMP: begin
        rd_fire = dout_rdy && (remaining_q != REM_ZERO);
        if (rd_fire) remaining_d = remaining_q - REM_ONE;
        else         remaining_d = remaining_q;
        if (rd_fire && (remaining_q == REM_ONE)) state_d = S_DONE;
        else                                     state_d = S_SAMP;
      end
      S_DONE: begin
        if (start_ok) state_d = S_HDR;
        else          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    vld_pipe_d     = vld_pipe_q;
    last_pipe_d    = last_pipe_q;
    vld_pipe_d[0]  = rd_fire;
    last_pipe_d[0] = rd_fire && (remaining_q == REM_ONE);
    for (int i = 1; i < P_RD_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end

    hdr_rdreq_d = (state_d == S_HDR);
    rddone_d    = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE) || (|vld_pipe_d);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_q      <= 1'b0;
      remaining_q <= REM_ZERO;
      evt_hdr_q   <= {P_HDR_WIDTH{1'b0}};
      vld_pipe_q  <= {P_RD_LATENCY{1'b0}};
      last_pipe_q <= {P_RD_LATENCY{1'b0}};
      hdr_rdreq_q <= 1'b0;
      hdr_valid_q <= 1'b0;
      rddone_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      remaining_q <= remaining_d;
      evt_hdr_q   <= evt_hdr_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      hdr_rdreq_q <= hdr_rdreq_d;
      hdr_valid_q <= hdr_valid_d;
      rddone_q    <= rddone_d;
      busy_q      <= busy_d;
    end
  end

  assign hdr_rdreq  = hdr_rdreq_q;
  assign wvb_rdreq  = rd_fire;
  assign wvb_rddone = rddone_q;
  assign evt_hdr    = evt_hdr_q;
  assign hdr_valid  = hdr_valid_q;
  assign dout_valid = vld_pipe_q[P_RD_LATENCY-1];
  assign dout_last  = last_pipe_q[P_RD_LATENCY-1];
  assign busy       = busy_q;

endmodule

// File: tb/tb_wvb_rd_sequencer.sv
// Scoreboard bench for wvb_rd_sequencer: a header FIFO model feeds the DUT; a monitor
// derives per-event expectations from each popped header and checks everything the DUT presents.
module tb_wvb_rd_sequencer;
  localparam int AW  = 12;
  localparam int HW  = 80;
  localparam int LAT = 2;
  localparam int NADR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          dout_rdy = 1'b0;
  logic          hdr_empty;
  logic [HW-1:0] hdr_data = '0;
  logic [AW-1:0] hdr_start_addr, hdr_stop_addr;
  logic          hdr_rdreq, wvb_rdreq, wvb_rddone, hdr_valid, dout_valid, dout_last, busy;
  logic [HW-1:0] evt_hdr;

  wvb_rd_sequencer #(.P_ADR_WIDTH(AW), .P_HDR_WIDTH(HW), .P_RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .hdr_empty(hdr_empty), .hdr_data(hdr_data),
    .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr), .dout_rdy(dout_rdy),
    .hdr_rdreq(hdr_rdreq), .wvb_rdreq(wvb_rdreq), .wvb_rddone(wvb_rddone), .evt_hdr(evt_hdr),
    .hdr_valid(hdr_valid), .dout_valid(dout_valid), .dout_last(dout_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Header FIFO model: registered (non-show-ahead) output, one pop per hdr_rdreq.
  logic [HW-1:0] hdr_mem [0:511];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign hdr_empty      = (wr_ptr == rd_ptr);
  assign hdr_start_addr = hdr_data[AW-1:0];
  assign hdr_stop_addr  = hdr_data[2*AW-1:AW];

  always @(posedge clk) begin
    if (hdr_rdreq && !hdr_empty) begin
      hdr_data <= hdr_mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // Scoreboard state, owned by the monitor.
  logic [HW-1:0] exp_hdr_q [$];
  int            exp_len_q [$];
  bit            exp_last_q [$];
  int rd_cyc_log [$], dv_cyc_log [$], last_cyc_log [$], hdr_cyc_log [$], done_cyc_log [$];
  logic [AW-1:0] rd_addr_log [$];
  logic [AW-1:0] addr_at_done_log [$];
  int in_evt = 0, cur_len = 0, rd_in_evt = 0, beats_low = 0;
  logic [AW-1:0] ctrl_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_hdr_q.delete();
      exp_len_q.delete();
      exp_last_q.delete();
      in_evt = 0;
    end else begin
      if (hdr_rdreq || wvb_rdreq || wvb_rddone)
        check("strobe_exclusive", int'(hdr_rdreq) + int'(wvb_rdreq) + int'(wvb_rddone), 1);
      if (hdr_rdreq) begin
        logic [HW-1:0] h;
        int s, e, n;
        check("pop_nonempty", hdr_empty, 0);
        h = hdr_mem[rd_ptr];
        s = int'(h[AW-1:0]);
        e = int'(h[2*AW-1:AW]);
        n = ((e - s + NADR) % NADR) + 1;
        exp_hdr_q.push_back(h);
        exp_len_q.push_back(n);
        for (int i = 1; i <= n; i++) exp_last_q.push_back(i == n);
        hdr_cyc_log.push_back(cyc);
      end
      if (hdr_valid) begin
        if (exp_hdr_q.size() == 0) begin
          check("hdr_valid_spurious", 1, 0);
        end else begin
          check("evt_hdr", evt_hdr, exp_hdr_q.pop_front());
          check("hdr_valid_latency", cyc - hdr_cyc_log[hdr_cyc_log.size()-1], 3);
          cur_len = exp_len_q.pop_front();
        end
        in_evt    = 1;
        rd_in_evt = 0;
        ctrl_addr = evt_hdr[AW-1:0];
      end
      if (wvb_rdreq) begin
        check("rdreq_in_event", in_evt, 1);
        check("rdreq_needs_rdy", dout_rdy, 1);
        rd_addr_log.push_back(ctrl_addr);
        ctrl_addr = ctrl_addr + 12'd1;
        rd_in_evt++;
        rd_cyc_log.push_back(cyc);
        check("rdreq_not_over", rd_in_evt <= cur_len, 1);
      end
      if (wvb_rddone) begin
        check("rddone_count", rd_in_evt, cur_len);
        addr_at_done_log.push_back(ctrl_addr);
        ctrl_addr = evt_hdr[2*AW-1:AW] + 12'd1;
        done_cyc_log.push_back(cyc);
        in_evt = 0;
      end
      if (dout_valid) begin
        if (exp_last_q.size() == 0) check("dout_valid_spurious", 1, 0);
        else                        check("dout_last", dout_last, exp_last_q.pop_front());
        dv_cyc_log.push_back(cyc);
        if (dout_last) last_cyc_log.push_back(cyc);
        if (!dout_rdy) beats_low++;
      end else if (dout_last) begin
        check("last_without_valid", 1, 0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_hdr(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [63:0] r;
    r = {$urandom, $urandom};
    hdr_mem[wr_ptr] = {r[HW-2*AW-1:0], e, s};
    wr_ptr++;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    tick(3);
    while ((busy || (en && !hdr_empty)) && k < budget) begin
      tick(1);
      k++;
    end
    check("idle_timeout", k < budget, 1);
  endtask

  task automatic wait_rd(input int base, input int n, input int budget);
    int k = 0;
    while ((rd_cyc_log.size() - base) < n && k < budget) begin
      tick(1);
      k++;
    end
    check("rd_wait_timeout", k < budget, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, d0, l0, h0, n0, a0, b0, r1, t;
    logic [AW-1:0] wrap_exp [4];
    wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF; wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h001;

    tick(3);
    check("reset_outputs", {hdr_rdreq, wvb_rdreq, wvb_rddone, hdr_valid, dout_valid, dout_last,
                            busy, |evt_hdr}, 0);
    rst = 1'b0;
    tick(2);
    check("idle_busy", busy, 0);

    // Single event at full rate.
    r0 = rd_cyc_log.size(); d0 = dv_cyc_log.size(); l0 = last_cyc_log.size();
    h0 = hdr_cyc_log.size(); n0 = done_cyc_log.size(); a0 = addr_at_done_log.size();
    dout_rdy = 1'b1; en = 1'b1;
    push_hdr(12'h010, 12'h013);
    wait_idle(100);
    t = hdr_cyc_log[h0];
    check("t1_rd_count", rd_cyc_log.size() - r0, 4);
    for (int i = 0; i < 4 && (r0 + i) < rd_cyc_log.size(); i++)
      check("t1_rd_cycle", rd_cyc_log[r0+i] - t, 3 + i);
    for (int i = 0; i < 4 && (d0 + i) < dv_cyc_log.size(); i++)
      check("t1_dv_cycle", dv_cyc_log[d0+i] - t, 3 + LAT + i);
    check("t1_last_cycle", last_cyc_log[l0] - t, 6 + LAT);
    check("t1_done_cycle", done_cyc_log[n0] - t, 7);
    check("t1_end_addr", addr_at_done_log[a0], 12'h014);

    // Wrap-around.
    r0 = rd_addr_log.size(); a0 = addr_at_done_log.size();
    push_hdr(12'hFFE, 12'h001);
    wait_idle(100);
    check("wrap_count", rd_addr_log.size() - r0, 4);
    for (int i = 0; i < 4 && (r0 + i) < rd_addr_log.size(); i++)
      check("wrap_addr", rd_addr_log[r0+i], wrap_exp[i]);
    check("wrap_end_addr", addr_at_done_log[a0], 12'h002);

    // Full buffer.
    r0 = rd_cyc_log.size(); l0 = last_cyc_log.size(); a0 = addr_at_done_log.size();
    push_hdr(12'h005, 12'h004);
    wait_idle(6000);
    check("full_rd_count", rd_cyc_log.size() - r0, NADR);
    check("full_last_count", last_cyc_log.size() - l0, 1);
    check("full_end_addr", addr_at_done_log[a0], 12'h005);

    // Backpressure after the 2nd rdreq of a 10-sample event.
    r0 = rd_cyc_log.size(); d0 = dv_cyc_log.size();
    push_hdr(12'h100, 12'h109);
    wait_rd(r0, 2, 50);
    dout_rdy = 1'b0;
    b0 = beats_low; r1 = rd_cyc_log.size();
    tick(5);
    check("bp_no_rdreq", rd_cyc_log.size() - r1, 0);
    check("bp_skid", (beats_low - b0) <= LAT, 1);
    dout_rdy = 1'b1;
    wait_idle(100);
    check("bp_rd_count", rd_cyc_log.size() - r0, 10);
    check("bp_dv_count", dv_cyc_log.size() - d0, 10);

    // Back-to-back events.
    h0 = hdr_cyc_log.size(); n0 = done_cyc_log.size();
    push_hdr(12'h200, 12'h202);
    push_hdr(12'h300, 12'h304);
    push_hdr(12'h400, 12'h401);
    wait_idle(200);
    check("b2b_pops", hdr_cyc_log.size() - h0, 3);
    check("b2b_dones", done_cyc_log.size() - n0, 3);
    check("b2b_period0", hdr_cyc_log[h0+1] - hdr_cyc_log[h0], 3 + 4);
    check("b2b_period1", hdr_cyc_log[h0+2] - hdr_cyc_log[h0+1], 5 + 4);

    // Reset mid-SAMP after 3 of 8 samples.
    r0 = rd_cyc_log.size();
    push_hdr(12'h500, 12'h507);
    wait_rd(r0, 3, 50);
    rst = 1'b1; dout_rdy = 1'b0;
    tick(1);
    check("rst_outputs", {hdr_rdreq, wvb_rdreq, wvb_rddone, hdr_valid, dout_valid, dout_last,
                          busy, |evt_hdr}, 0);
    n0 = done_cyc_log.size(); h0 = hdr_cyc_log.size();
    rst = 1'b0; dout_rdy = 1'b1;
    tick(20);
    check("rst_no_rddone", done_cyc_log.size() - n0, 0);
    check("rst_stays_idle", busy, 0);
    check("rst_no_pop", hdr_cyc_log.size() - h0, 0);

    // Dropping en mid-event.
    h0 = hdr_cyc_log.size(); n0 = done_cyc_log.size();
    push_hdr(12'h600, 12'h603);
    push_hdr(12'h700, 12'h701);
    begin
      int k = 0;
      while (hdr_cyc_log.size() == h0 && k < 20) begin
        tick(1);
        k++;
      end
      check("en_pop_timeout", k < 20, 1);
    end
    en = 1'b0;
    wait_idle(100);
    tick(5);
    check("en_one_pop", hdr_cyc_log.size() - h0, 1);
    check("en_event_done", done_cyc_log.size() - n0, 1);
    check("en_fifo_left", wr_ptr - rd_ptr, 1);
    en = 1'b1;
    wait_idle(100);

    // Randomized events with random backpressure.
    n0 = done_cyc_log.size();
    for (int ev = 0; ev < 40; ev++) begin
      logic [AW-1:0] s, len;
      s   = AW'($urandom);
      len = AW'($urandom_range(1, 40));
      push_hdr(s, s + len - 12'd1);
      for (int c = 0; c < int'($urandom_range(0, 15)); c++) begin
        dout_rdy = ($urandom_range(0, 9) < 7);
        tick(1);
      end
    end
    dout_rdy = 1'b1;
    wait_idle(5000);
    check("rand_dones", done_cyc_log.size() - n0, 40);
    check("rand_hdr_drained", exp_hdr_q.size(), 0);
    check("rand_beats_drained", exp_last_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
